spi_slave_link: RTL and testbench

Byte-oriented SPI responder core, mode 0 (CPOL=0, CPHA=0), MSB first. It sits in s_top between the SCLK/MOSI/SS/MISO pins and the slave's application logic. It oversamples the master's pins on clk and returns reply bytes on MISO from a one-entry transmit holding register. It is the receive-and-reply counterpart to the master's transmitter in m_top.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave_link.sv | 165 ++++++++++++++++
 tb/tb_spi_slave_link.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder link.
package spi_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;

  localparam bit         SPI_CPOL       = 1'b0;
  localparam bit         SPI_CPHA       = 1'b0;
  localparam int         SPI_DATA_W     = 8;
  localparam logic [7:0] SPI_DEFAULT_TX = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_reg;
  logic              prev_reg;

  // Chain clears to 0 so a select already held low after reset never looks like a fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_reg <= '0;
      prev_reg  <= 1'b0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], din};
      prev_reg  <= chain_reg[STAGES-1];
    end
  end

  assign sync = chain_reg[STAGES-1];
  assign rise = sync & ~prev_reg;
  assign fall = ~sync & prev_reg;

endmodule

// File: rtl/spi_slave_link.sv
// Mode-0 MSB-first SPI responder: oversampled pins, rx word output, one-entry reply holding register.
module spi_slave_link
  import spi_pkg::*;
#(
  parameter int                DATA_W      = SPI_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] DEFAULT_TX  = SPI_DEFAULT_TX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCLK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_chain_reg;
  logic mosi_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(SCLK),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk(clk), .reset(reset), .din(SS),
    .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) mosi_chain_reg <= '0;
    else       mosi_chain_reg <= {mosi_chain_reg[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_sync = mosi_chain_reg[SYNC_STAGES-1];

  spi_state_t        state_reg;
  logic [CNT_W-1:0]  bit_cnt_reg, cnt_next;
  logic [DATA_W-2:0] rx_shift_reg;
  logic [DATA_W-1:0] tx_shift_reg, hold_data_reg, load_word, rx_word;
  logic              hold_full_reg, boundary_reg, pending_reg, pending_hold_reg;
  logic              miso_reg, rx_valid_reg, underrun_reg, abort_reg;
  logic [DATA_W-1:0] rx_data_reg;
  logic              start_load, word_done, write_hold;

  // A frame starts only when the select falls while SCLK sits at its idle level.
  assign start_load = (state_reg == ST_IDLE) && ss_fall && !ss_sync && (sclk_sync == SPI_CPOL);
  assign word_done  = (state_reg == ST_SHIFT) && sclk_rise && (bit_cnt_reg == LAST_BIT);
  assign write_hold = tx_valid && !hold_full_reg && !start_load;
  assign rx_word    = {rx_shift_reg, mosi_sync};

  always_comb begin
    load_word = DEFAULT_TX;
    if (hold_full_reg) load_word = hold_data_reg;
    else if (tx_valid) load_word = tx_data;
  end

  always_comb begin
    cnt_next = bit_cnt_reg;
    if ((state_reg == ST_SHIFT) && sclk_rise)
      cnt_next = word_done ? '0 : bit_cnt_reg + CNT_W'(1);
  end

  // Word-boundary loads are committed on the next word's first rising edge, so the
  // trailing SCLK fall of a frame neither consumes a queued reply nor flags underrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      bit_cnt_reg      <= '0;
      rx_shift_reg     <= '0;
      tx_shift_reg     <= '0;
      hold_data_reg    <= '0;
      hold_full_reg    <= 1'b0;
      boundary_reg     <= 1'b0;
      pending_reg      <= 1'b0;
      pending_hold_reg <= 1'b0;
      miso_reg         <= 1'b0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      underrun_reg     <= 1'b0;
      abort_reg        <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      underrun_reg <= 1'b0;
      abort_reg    <= 1'b0;
      if (write_hold) begin
        hold_data_reg <= tx_data;
        hold_full_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          miso_reg     <= 1'b0;
          bit_cnt_reg  <= '0;
          boundary_reg <= 1'b0;
          pending_reg  <= 1'b0;
          if (start_load) begin
            state_reg    <= ST_SHIFT;
            tx_shift_reg <= load_word;
            miso_reg     <= load_word[DATA_W-1];
            if (hold_full_reg) hold_full_reg <= 1'b0;
            else if (!tx_valid) underrun_reg <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            rx_shift_reg <= rx_word[DATA_W-2:0];
            bit_cnt_reg  <= cnt_next;
            if (word_done) begin
              rx_data_reg  <= rx_word;
              rx_valid_reg <= 1'b1;
              boundary_reg <= 1'b1;
            end
            if (pending_reg) begin
              pending_reg <= 1'b0;
              if (pending_hold_reg) hold_full_reg <= 1'b0;
              else                  underrun_reg  <= 1'b1;
            end
          end
          if (sclk_fall) begin
            if (boundary_reg) begin
              tx_shift_reg     <= load_word;
              miso_reg         <= load_word[DATA_W-1];
              boundary_reg     <= 1'b0;
              pending_reg      <= 1'b1;
              pending_hold_reg <= hold_full_reg || tx_valid;
            end else begin
              tx_shift_reg <= tx_shift_reg << 1;
              miso_reg     <= tx_shift_reg[DATA_W-2];
            end
          end
          if (ss_rise) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            miso_reg     <= 1'b0;
            boundary_reg <= 1'b0;
            pending_reg  <= 1'b0;
            if (cnt_next != '0) abort_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign MISO        = miso_reg;
  assign tx_ready    = ~hold_full_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign busy        = (state_reg == ST_SHIFT);
  assign tx_underrun = underrun_reg;
  assign frame_abort = abort_reg;

endmodule

// File: tb/tb_spi_slave_link.sv
// Scoreboard bench for spi_slave_link: directed SPI frames from a bit-banged master.
module tb_spi_slave_link;

  localparam int HALF = 8;

  logic       clk, reset, SCLK, SS, MOSI, MISO;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, busy, tx_underrun, frame_abort;

  int n_checks = 0;
  int n_fail   = 0;
  int rxv_cnt  = 0;
  int und_cnt  = 0;
  int abort_cnt = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] miso_cap_q[$];

  spi_slave_link dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .tx_underrun(tx_underrun), .frame_abort(frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops expectations whenever the DUT or the master capture presents a word.
  always @(negedge clk) begin
    logic [7:0] cap;
    if (rx_valid === 1'b1) begin
      rxv_cnt++;
      if (exp_rx_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got rx_data=%0h, required no rx_valid", rx_data);
      end else begin
        check("rx_data", rx_data, exp_rx_q.pop_front());
      end
    end
    if (tx_underrun === 1'b1) und_cnt++;
    if (frame_abort === 1'b1) abort_cnt++;
    if (miso_cap_q.size() != 0) begin
      cap = miso_cap_q.pop_front();
      if (exp_miso_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL miso_unexpected: got %0h, required no word", cap);
      end else begin
        check("miso_word", cap, exp_miso_q.pop_front());
      end
    end
  end

  task automatic write_tx(input logic [7:0] d);
    bit done;
    done = 1'b0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (tx_ready) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) check("tx_handshake_timeout", 32'(tx_ready), 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic spi_frame(input int nwords, input logic [7:0] w0, input logic [7:0] w1,
                           input int stop_after, input bit capture,
                           input bit bypass, input logic [7:0] bypass_data);
    logic [7:0] cap, w;
    int  edges;
    bit  stop;
    edges = 0;
    stop  = 1'b0;
    cap   = '0;
    @(negedge clk);
    MOSI = w0[7];
    SS   = 1'b0;
    if (bypass) begin
      wait_clk(2);
      tx_data  = bypass_data;
      tx_valid = 1'b1;
      wait_clk(1);
      tx_valid = 1'b0;
      check("bypass_tx_ready", 32'(tx_ready), 1);
      wait_clk(HALF - 3);
    end else begin
      wait_clk(HALF);
    end
    for (int k = 0; k < nwords && !stop; k++) begin
      w = (k == 0) ? w0 : w1;
      for (int b = 7; b >= 0 && !stop; b--) begin
        MOSI = w[b];
        if (!(k == 0 && b == 7)) wait_clk(HALF);
        SCLK = 1'b1;
        cap = {cap[6:0], MISO};
        edges++;
        wait_clk(HALF);
        SCLK = 1'b0;
        if (stop_after != 0 && edges == stop_after) stop = 1'b1;
      end
      if (capture && !stop) miso_cap_q.push_back(cap);
    end
    wait_clk(HALF);
    SS   = 1'b1;
    MOSI = 1'b0;
    wait_clk(2 * HALF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, r0, a0;
    reset = 1'b1; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    wait_clk(5);
    check("rst_miso", 32'(MISO), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_underrun", 32'(tx_underrun), 0);
    check("rst_abort", 32'(frame_abort), 0);
    reset = 1'b0;
    wait_clk(4);

    // 1: queued reply A5, master sends 3C
    write_tx(8'hA5);
    exp_miso_q.push_back(8'hA5);
    exp_rx_q.push_back(8'h3C);
    u0 = und_cnt; r0 = rxv_cnt;
    spi_frame(1, 8'h3C, 8'h00, 0, 1, 0, 8'h00);
    check("t1_underrun_cnt", und_cnt - u0, 0);
    check("t1_rx_valid_cnt", rxv_cnt - r0, 1);
    check("t1_tx_ready", 32'(tx_ready), 1);

    // 2: nothing queued -> default reply
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h00);
    u0 = und_cnt;
    spi_frame(1, 8'h00, 8'h00, 0, 1, 0, 8'h00);
    check("t2_underrun_cnt", und_cnt - u0, 1);

    // 3: two back-to-back words, second reply written mid-word
    write_tx(8'h11);
    exp_miso_q.push_back(8'h11);
    exp_miso_q.push_back(8'h22);
    exp_rx_q.push_back(8'h5A);
    exp_rx_q.push_back(8'hC3);
    u0 = und_cnt; r0 = rxv_cnt;
    fork
      spi_frame(2, 8'h5A, 8'hC3, 0, 1, 0, 8'h00);
      begin
        wait_clk(40);
        check("t3_busy", 32'(busy), 1);
        write_tx(8'h22);
      end
    join
    check("t3_underrun_cnt", und_cnt - u0, 0);
    check("t3_rx_valid_cnt", rxv_cnt - r0, 2);
    check("t3_tx_ready", 32'(tx_ready), 1);

    // 4: abort after 5 rising edges, then a full frame
    u0 = und_cnt; r0 = rxv_cnt; a0 = abort_cnt;
    spi_frame(1, 8'hF0, 8'h00, 5, 0, 0, 8'h00);
    check("t4_abort_cnt", abort_cnt - a0, 1);
    check("t4_rx_valid_cnt", rxv_cnt - r0, 0);
    check("t4_busy", 32'(busy), 0);
    check("t4_underrun_cnt", und_cnt - u0, 1);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h81);
    spi_frame(1, 8'h81, 8'h00, 0, 1, 0, 8'h00);
    check("t4_rx_data", 32'(rx_data), 32'h81);

    // 5: reset during bit 4 with a reply queued
    r0 = rxv_cnt; a0 = abort_cnt;
    fork
      spi_frame(1, 8'hA3, 8'h00, 0, 0, 0, 8'h00);
      begin
        wait_clk(20);
        write_tx(8'h5C);
        check("t5_tx_ready_full", 32'(tx_ready), 0);
        wait_clk(35);
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        check("t5_miso", 32'(MISO), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_tx_ready", 32'(tx_ready), 1);
        check("t5_rx_data", 32'(rx_data), 0);
      end
    join
    check("t5_rx_valid_cnt", rxv_cnt - r0, 0);
    check("t5_abort_cnt", abort_cnt - a0, 0);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h7E);
    u0 = und_cnt;
    spi_frame(1, 8'h7E, 8'h00, 0, 1, 0, 8'h00);
    check("t5_underrun_cnt", und_cnt - u0, 1);

    // 6: bypass in the exact select-fall load cycle
    exp_miso_q.push_back(8'h96);
    exp_rx_q.push_back(8'h69);
    u0 = und_cnt;
    spi_frame(1, 8'h69, 8'h00, 0, 1, 1, 8'h96);
    check("t6_underrun_cnt", und_cnt - u0, 0);
    check("t6_tx_ready", 32'(tx_ready), 1);

    wait_clk(20);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("miso_queue_drained", exp_miso_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
